instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Multi-cycle control FSM that drives the fetch/decode datapath: it steps the
//  program counter through the 32-word instruction memory, latches each 20-bit
//  instruction, presents register read addresses, starts the ALU with a
//  start/done handshake, and issues the write-back strobe.
//  It sits between the fetch MUX, the register file and the ALU.
// PARAMETERS
//  WORD_W   20     instruction/data word width
//  ADDR_W   5      width of opcode and each address field; memory depth = 2**ADDR_W
//  NOP_OP   5'h00  opcode that skips EXEC and WRITE
//  HALT_OP  5'h1F  opcode that stops the sequencer
//  MAX_WAIT 15     max EXEC cycles spent waiting for alu_done before timeout
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-high reset
//  start      in   1       level; sampled in IDLE/HALT to begin at pc = 0
//  instr_in   in   WORD_W  instruction from fetch MUX for the current pc (combinational)
//  alu_done   in   1       ALU result valid; may be held high
//  pc         out  WORD_W  instruction index into fetch MUX (low ADDR_W bits used)
//  ir         out  WORD_W  latched instruction register
//  rd_addr_a  out  ADDR_W  register-file read address A = ir[9:5]
//  rd_addr_b  out  ADDR_W  register-file read address B = ir[14:10]
//  alu_op     out  ADDR_W  opcode = ir[4:0]
//  alu_start  out  1       one-cycle pulse starting the ALU
//  wr_addr    out  ADDR_W  write-back address = ir[19:15]
//  wr_en      out  1       one-cycle write-back strobe
//  busy       out  1       high in every state except IDLE and HALT
//  halted     out  1       high in HALT
//  timeout    out  1       sticky; set on ALU timeout, cleared only by rst or start
// BEHAVIOUR
//  All outputs are registered. Reset (async) forces state=IDLE; pc, ir,
//   addresses, alu_op, alu_start, wr_en, busy, halted, timeout and wait_cnt = 0.
//  States: IDLE, FETCH, DECODE, EXEC, WRITE, HALT.
//  IDLE : start=1 -> pc<=0, timeout<=0, go FETCH.
//  FETCH: ir<=instr_in (one cycle) -> DECODE.
//  DECODE: drive rd_addr_a/b, alu_op, wr_addr from ir.
//   If opcode == HALT_OP -> HALT (pc unchanged).
//   If opcode == NOP_OP -> pc<=pc+1, go FETCH.
//   Otherwise alu_start<=1 (exactly one cycle), wait_cnt<=0, go EXEC.
//  EXEC : alu_start=0. alu_done=1 -> WRITE. Otherwise wait_cnt++.
//   If wait_cnt reaches MAX_WAIT without alu_done: timeout<=1, go HALT, no write.
//   alu_done seen in the same cycle as the last permitted wait count wins (-> WRITE).
//  WRITE: wr_en=1 for exactly one cycle with wr_addr stable; pc<=pc+1; go FETCH.
//  pc arithmetic is modulo 2**WORD_W. Fetch uses pc[ADDR_W-1:0], so address 31
//   wraps to 0 with no special case.
//  Instruction latency, from FETCH entry: NOP = 2 cycles; ALU op = 4 + k cycles,
//   where k = alu_done wait cycles (k=0 if done in the first EXEC cycle).
//  HALT : busy=0, halted=1; outputs hold. start=1 -> pc<=0, timeout<=0, go FETCH.
//  alu_done is ignored outside EXEC. start is ignored while busy.
//  Reset asserted mid-instruction aborts it immediately. No wr_en or alu_start
//   pulse may be produced during or after reset until a new start.
//  wr_en and alu_start are never high in the same cycle.
// TESTING
//  1 rst, start=1, mem[0]=ADD(op 01, A=2, B=3, W=4), alu_done after 2 cycles
//    -> alu_start 1 cycle; rd_addr_a=2, rd_addr_b=3; wr_en 1 cycle with wr_addr=4; pc=1.
//  2 mem[0..2]=NOP,NOP,HALT -> pc steps 0,1,2; no alu_start or wr_en;
//    halted=1 with pc=2, ir=HALT.
//  3 pc=31 executing an ALU op -> pc becomes 32 and fetch index wraps to 0;
//    instr_in for mem[0] is latched next.
//  4 alu_done held low -> timeout=1 after MAX_WAIT=15 EXEC cycles, state HALT,
//    no wr_en; then start=1 clears timeout and restarts at pc=0.
//  5 rst asserted during EXEC with alu_done pulsing -> all outputs 0 at once, IDLE;
//    no wr_en until next start.
//  6 alu_done=1 held constantly through DECODE -> still exactly one alu_start and
//    one wr_en per instruction.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/write-back sequencer for a 32-word program store.
// Starts the ALU with a start/done handshake and gives up after a bounded wait.
module instr_sequencer #(
  parameter int                WORD_W   = 20,
  parameter int                ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] NOP_OP   = 5'h00,
  parameter logic [ADDR_W-1:0] HALT_OP  = 5'h1F,
  parameter int                MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] instr_in,
  input  logic              alu_done,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] ir,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [ADDR_W-1:0] alu_op,
  output logic              alu_start,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              busy,
  output logic              halted,
  output logic              timeout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam int OP_FIELD = 0;
  localparam int A_FIELD  = 1;
  localparam int B_FIELD  = 2;
  localparam int W_FIELD  = 3;

  localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
  localparam logic [WORD_W-1:0] PC_ONE    = {{(WORD_W-1){1'b0}}, 1'b1};
  localparam logic [WORD_W-1:0] WORD_ZERO = {WORD_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  // Instruction word layout: [W | B | A | OP], each ADDR_W bits wide.
  function automatic logic [ADDR_W-1:0] field_of(input logic [WORD_W-1:0] word, input int idx);
    field_of = word[idx*ADDR_W +: ADDR_W];
  endfunction

  logic [2:0]        state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] rd_a_q, rd_a_d;
  logic [ADDR_W-1:0] rd_b_q, rd_b_d;
  logic [ADDR_W-1:0] op_q, op_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              alu_start_q, alu_start_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              timeout_q, timeout_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ADDR_W-1:0] dec_op;

  assign dec_op = field_of(ir_q, OP_FIELD);

  // Next-state and next-output logic; busy/halted follow the state being entered.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    rd_a_d      = rd_a_q;
    rd_b_d      = rd_b_q;
    op_d        = op_q;
    wr_addr_d   = wr_addr_q;
    alu_start_d = 1'b0;
    wr_en_d     = 1'b0;
    wait_d      = wait_q;
    timeout_d   = timeout_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d      = WORD_ZERO;
          timeout_d = 1'b0;
          state_d   = S_FETCH;
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: begin
        ir_d    = instr_in;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d      = dec_op;
        rd_a_d    = field_of(ir_q, A_FIELD);
        rd_b_d    = field_of(ir_q, B_FIELD);
        wr_addr_d = field_of(ir_q, W_FIELD);
        if (dec_op == HALT_OP) begin
          state_d = S_HALT;
        end else if (dec_op == NOP_OP) begin
          pc_d    = pc_q + PC_ONE;
          state_d = S_FETCH;
        end else begin
          alu_start_d = 1'b1;
          wait_d      = WAIT_ZERO;
          state_d     = S_EXEC;
        end
      end
      S_EXEC: begin
        // A done arriving on the final permitted wait cycle still wins over timeout.
        if (alu_done) begin
          wr_en_d = 1'b1;
          state_d = S_WRITE;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      S_WRITE: begin
        pc_d    = pc_q + PC_ONE;
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d = (state_d == S_HALT);
  end

  // State and registered outputs; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= WORD_ZERO;
      ir_q        <= WORD_ZERO;
      rd_a_q      <= ADDR_ZERO;
      rd_b_q      <= ADDR_ZERO;
      op_q        <= ADDR_ZERO;
      wr_addr_q   <= ADDR_ZERO;
      alu_start_q <= 1'b0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      wait_q      <= WAIT_ZERO;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      rd_a_q      <= rd_a_d;
      rd_b_q      <= rd_b_d;
      op_q        <= op_d;
      wr_addr_q   <= wr_addr_d;
      alu_start_q <= alu_start_d;
      wr_en_q     <= wr_en_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      timeout_q   <= timeout_d;
      wait_q      <= wait_d;
    end
  end

  assign pc        = pc_q;
  assign ir        = ir_q;
  assign rd_addr_a = rd_a_q;
  assign rd_addr_b = rd_b_q;
  assign alu_op    = op_q;
  assign wr_addr   = wr_addr_q;
  assign alu_start = alu_start_q;
  assign wr_en     = wr_en_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed and random programs checked against an
// instruction-level timing model built from the latency rules.
module tb_instr_sequencer;

  localparam int         MAX_WAIT = 15;
  localparam logic [4:0] NOP      = 5'h00;
  localparam logic [4:0] HALT     = 5'h1F;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        alu_done;
  logic [19:0] instr_in;
  logic [19:0] pc;
  logic [19:0] ir;
  logic [4:0]  rd_addr_a, rd_addr_b, alu_op, wr_addr;
  logic        alu_start, wr_en, busy, halted, timeout;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .instr_in(instr_in), .alu_done(alu_done),
    .pc(pc), .ir(ir), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .alu_op(alu_op),
    .alu_start(alu_start), .wr_addr(wr_addr), .wr_en(wr_en), .busy(busy),
    .halted(halted), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] f0;
    logic [4:0] f1;
    logic [4:0] f2;
  } ev_t;

  ev_t         exp_st[$], obs_st[$], exp_wr[$], obs_wr[$];
  logic [19:0] mem [32];
  logic [19:0] mem0_alt;
  int          kq[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_halt_c;
  logic [19:0] exp_pc, exp_ir;
  logic        exp_to;

  // Program store: once pc has wrapped past 31, index 0 may hold a different word.
  always_comb begin
    if (pc[4:0] == 5'd0 && pc != 20'd0) instr_in = mem0_alt;
    else                                instr_in = mem[pc[4:0]];
  end

  function automatic logic [19:0] mk(input logic [4:0] w, input logic [4:0] b,
                                     input logic [4:0] a, input logic [4:0] op);
    return {w, b, a, op};
  endfunction

  function automatic logic [19:0] fetched(input logic [19:0] p);
    if (p[4:0] == 5'd0 && p != 20'd0) return mem0_alt;
    else                              return mem[p[4:0]];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"}, {12'd0, pc}, 32'd0);
    check({tag, "_ir"}, {12'd0, ir}, 32'd0);
    check({tag, "_ctl"}, {7'd0, rd_addr_a, rd_addr_b, alu_op, wr_addr,
                          alu_start, wr_en, busy, halted, timeout}, 32'd0);
  endtask

  task automatic fill_random();
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r = $urandom();
      mem[i] = r[19:0];
    end
    mem0_alt = mem[0];
  endtask

  // Timeline per instruction from its FETCH cycle c: NOP lasts 2, ALU op 4+k,
  // HALT is reached 2 cycles in, timeout after MAX_WAIT idle EXEC cycles.
  task automatic build_model(input bit hold);
    logic [19:0] p;
    logic [19:0] ins;
    int c, ai, k;
    ev_t e;
    p = 20'd0; c = 0; ai = 0; ins = 20'd0;
    exp_st.delete(); exp_wr.delete();
    exp_to = 1'b0; exp_halt_c = -1;
    for (int n = 0; n < 400; n++) begin
      ins = fetched(p);
      if (ins[4:0] == HALT) begin
        exp_halt_c = c + 2;
        break;
      end else if (ins[4:0] == NOP) begin
        c += 2; p = p + 20'd1;
      end else begin
        k = hold ? 0 : ((ai < kq.size()) ? kq[ai] : 0);
        ai++;
        e.cyc = c + 2; e.f0 = ins[9:5]; e.f1 = ins[14:10]; e.f2 = ins[4:0];
        exp_st.push_back(e);
        if (k < MAX_WAIT) begin
          e.cyc = c + 3 + k; e.f0 = ins[19:15]; e.f1 = 5'd0; e.f2 = 5'd0;
          exp_wr.push_back(e);
          c += 4 + k; p = p + 20'd1;
        end else begin
          exp_to = 1'b1;
          exp_halt_c = c + 2 + MAX_WAIT;
          break;
        end
      end
    end
    exp_pc = p; exp_ir = ins;
  endtask

  // Start the program, play the ALU (done k cycles after each start), then compare.
  task automatic run_prog(input string tag, input bit hold, input bit noise);
    int c, ai, cnt, cur_k;
    bit active;
    logic [31:0] r;
    ev_t e;
    build_model(hold);
    obs_st.delete(); obs_wr.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_restart"}, {10'd0, busy, timeout, pc}, {10'd0, 1'b1, 1'b0, 20'd0});
    c = 0; ai = 0; cnt = 0; cur_k = 0; active = 1'b0;
    while (halted !== 1'b1 && c < 3000) begin
      if (alu_start === 1'b1) begin
        e.cyc = c; e.f0 = rd_addr_a; e.f1 = rd_addr_b; e.f2 = alu_op;
        obs_st.push_back(e);
        cur_k = (ai < kq.size()) ? kq[ai] : 0;
        ai++; cnt = 0; active = 1'b1;
      end
      if (wr_en === 1'b1) begin
        e.cyc = c; e.f0 = wr_addr; e.f1 = 5'd0; e.f2 = 5'd0;
        obs_wr.push_back(e);
      end
      check({tag, "_overlap"}, {31'd0, alu_start & wr_en}, 32'd0);
      check({tag, "_busy"}, {30'd0, busy, halted}, 32'd2);
      if (hold) begin
        alu_done = 1'b1;
      end else if (active) begin
        alu_done = (cnt == cur_k);
        if (cnt == cur_k) active = 1'b0;
        cnt++;
      end else if (noise) begin
        r = $urandom();
        alu_done = r[0];
      end else begin
        alu_done = 1'b0;
      end
      @(posedge clk); #1;
      c++;
    end
    alu_done = 1'b0;
    check({tag, "_halted"}, {31'd0, halted}, 32'd1);
    check({tag, "_halt_cycle"}, c, exp_halt_c);
    check({tag, "_pc"}, {12'd0, pc}, {12'd0, exp_pc});
    check({tag, "_ir"}, {12'd0, ir}, {12'd0, exp_ir});
    check({tag, "_timeout"}, {31'd0, timeout}, {31'd0, exp_to});
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, "_dec_fields"}, {12'd0, alu_op, rd_addr_a, rd_addr_b, wr_addr},
          {12'd0, exp_ir[4:0], exp_ir[9:5], exp_ir[14:10], exp_ir[19:15]});
    check({tag, "_n_start"}, obs_st.size(), exp_st.size());
    check({tag, "_n_write"}, obs_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_st.size() && i < obs_st.size(); i++) begin
      check({tag, "_start_cyc"}, obs_st[i].cyc, exp_st[i].cyc);
      check({tag, "_start_fld"}, {17'd0, obs_st[i].f0, obs_st[i].f1, obs_st[i].f2},
            {17'd0, exp_st[i].f0, exp_st[i].f1, exp_st[i].f2});
    end
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
      check({tag, "_wr_cyc"}, obs_wr[i].cyc, exp_wr[i].cyc);
      check({tag, "_wr_addr"}, {27'd0, obs_wr[i].f0}, {27'd0, exp_wr[i].f0});
    end
  endtask

  initial begin
    logic [31:0] r;
    int n, c;
    rst = 1'b1; start = 1'b0; alu_done = 1'b0;
    fill_random();
    @(posedge clk); #1;
    check_reset("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single ADD with done after 2 wait cycles
    fill_random();
    mem[0] = mk(5'd4, 5'd3, 5'd2, 5'h01); mem[1] = mk(5'd0, 5'd0, 5'd0, HALT); mem0_alt = mem[0];
    kq = '{2};
    run_prog("add", 1'b0, 1'b0);

    // NOP, NOP, HALT
    fill_random();
    mem[0] = mk(5'd9, 5'd1, 5'd7, NOP); mem[1] = mk(5'd3, 5'd5, 5'd6, NOP);
    mem[2] = mk(5'd1, 5'd2, 5'd3, HALT); mem0_alt = mem[0];
    kq = '{};
    run_prog("nop", 1'b0, 1'b0);

    // Done on the last permitted wait cycle
    fill_random();
    mem[0] = mk(5'd17, 5'd11, 5'd12, 5'h05); mem[1] = mk(5'd2, 5'd2, 5'd2, HALT); mem0_alt = mem[0];
    kq = '{14};
    run_prog("lastwait", 1'b0, 1'b0);

    // Timeout, then restart clears it
    kq = '{15};
    run_prog("timeout", 1'b0, 1'b0);
    kq = '{1};
    run_prog("after_to", 1'b0, 1'b0);

    // ALU op at pc 31, wrap to index 0 which now holds HALT
    fill_random();
    mem[0] = mk(5'd1, 5'd2, 5'd3, 5'h02);
    for (int i = 1; i < 31; i++) begin
      r = $urandom();
      mem[i] = {r[14:0], NOP};
    end
    mem[31] = mk(5'd21, 5'd22, 5'd23, 5'h1E);
    mem0_alt = mk(5'd9, 5'd8, 5'd7, HALT);
    kq = '{0, 3};
    run_prog("wrap", 1'b0, 1'b1);

    // alu_done held high throughout
    fill_random();
    mem[0] = mk(5'd5, 5'd6, 5'd7, 5'h03); mem[1] = mk(5'd8, 5'd9, 5'd10, 5'h04);
    mem[2] = mk(5'd0, 5'd0, 5'd0, NOP);   mem[3] = mk(5'd11, 5'd12, 5'd13, 5'h1E);
    mem[4] = mk(5'd0, 5'd0, 5'd0, HALT);  mem0_alt = mem[0];
    kq = '{};
    run_prog("hold", 1'b1, 1'b0);

    // Reset in EXEC with alu_done pulsing
    fill_random();
    mem[0] = mk(5'd7, 5'd6, 5'd5, 5'h0A); mem[1] = mk(5'd0, 5'd0, 5'd0, HALT); mem0_alt = mem[0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (alu_start !== 1'b1 && c < 10) begin
      @(posedge clk); #1;
      c++;
    end
    check("rst_reach_exec", {31'd0, alu_start}, 32'd1);
    alu_done = 1'b0; #3;
    alu_done = 1'b1; #1;
    rst = 1'b1; #1;
    check_reset("rst_mid_exec");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      alu_done = ~alu_done;
      check("rst_no_pulse", {30'd0, wr_en, alu_start}, 32'd0);
      check("rst_idle", {30'd0, busy, halted}, 32'd0);
      if (i == 2) rst = 1'b0;
    end
    alu_done = 1'b0;
    check_reset("rst_after");
    kq = '{0};
    run_prog("post_rst", 1'b0, 1'b0);

    // Random programs
    for (int t = 0; t < 6; t++) begin
      fill_random();
      r = $urandom_range(10, 3);
      n = int'(r);
      kq = '{};
      for (int i = 0; i < n; i++) begin
        r = $urandom();
        if (r[31:29] < 3'd2) begin
          mem[i] = {r[14:0], NOP};
        end else begin
          mem[i] = {r[14:0], 5'h01 + {2'd0, r[28:26]} + {2'd0, r[25:23]} * 5'd3};
          if (r[22:19] == 4'd0) kq.push_back(15);
          else kq.push_back(int'($urandom_range(14, 0)));
        end
      end
      r = $urandom();
      mem[n] = {r[14:0], HALT};
      mem0_alt = mem[0];
      run_prog("rand", 1'b0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
